// File: rtl/mem_stage_param.sv
// mem_stage_param
// ----------------------------------------------------------------------------
// MEM pipeline stage between the EXE/MEM and MEM/WB registers. It owns a
// word-organised data memory and performs byte-lane masked loads and stores.
// Store data is steered onto lanes by the low address bits. Load data is
// right-aligned and then sign- or zero-extended. Misaligned or malformed
// accesses are flagged as faults and never touch memory. A programmable
// number of wait cycles (MEM_LAT) is modelled with a small counter that
// stalls the upstream stages.
//
// Ports
//   clk, reset_n          clock; asynchronous active-low reset
//   valid_EXE_MEM         instruction in EXE/MEM is real
//   MemRead_EXE           load size mask (low-contiguous ones, count 1,2,4..NB)
//   MemWrite_EXE          store size mask (same encoding)
//   LoadSigned_EXE        1 = sign-extend load data, 0 = zero-extend
//   ALU_Result_EXE_MEM    byte address, or ALU result for non-memory ops
//   write_data_EXE_MEM    store data, LSB-aligned
//   MemtoReg_EXE_MEM      writeback select, passed through
//   RegWrite_EXE_MEM      register write enable
//   rd_EXE_MEM            destination register
//   pc_EXE_MEM            instruction PC
//   stall_MEM             stage busy; upstream holds its inputs
//   *_MEM_WB              MEM/WB pipeline register outputs
//
// Handshake: while stall_MEM=1 the upstream stage keeps every EXE/MEM input
// stable, and each such edge loads a bubble into MEM/WB. The edge on which
// stall_MEM=0 consumes the instruction and loads its result into MEM/WB.
// ----------------------------------------------------------------------------
module mem_stage_param #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int PC_W    = 15,
   parameter int REG_W   = 5,
   parameter int MEM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  valid_EXE_MEM,
   input  logic [DATA_W/8-1:0]   MemRead_EXE,
   input  logic [DATA_W/8-1:0]   MemWrite_EXE,
   input  logic                  LoadSigned_EXE,
   input  logic [DATA_W-1:0]     ALU_Result_EXE_MEM,
   input  logic [DATA_W-1:0]     write_data_EXE_MEM,
   input  logic [1:0]            MemtoReg_EXE_MEM,
   input  logic                  RegWrite_EXE_MEM,
   input  logic [REG_W-1:0]      rd_EXE_MEM,
   input  logic [PC_W-1:0]       pc_EXE_MEM,
   output logic                  stall_MEM,
   output logic [DATA_W-1:0]     read_data_MEM_WB,
   output logic [DATA_W-1:0]     ALU_Result_MEM_WB,
   output logic [1:0]            MemtoReg_MEM_WB,
   output logic                  RegWrite_MEM_WB,
   output logic [REG_W-1:0]      write_reg_MEM_WB,
   output logic [DATA_W-1:0]     pc_MEM_WB,
   output logic                  valid_MEM_WB,
   output logic                  fault_MEM_WB
);

   localparam int NB = DATA_W / 8;
   localparam int OB = $clog2(NB);
   localparam int IW = $clog2(DEPTH);
   localparam logic [2:0]    LAT  = 3'(MEM_LAT);
   localparam logic [NB-1:0] ONES = '1;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t             state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;

   logic               rd_any, wr_any;
   logic [NB-1:0]      acc_mask;
   logic               size_ok;
   logic [OB-1:0]      off, off_mask;
   logic               misalign;
   logic               fault;
   logic               memop;
   logic               stall_int;
   logic               complete;
   logic [IW-1:0]      idx;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [DATA_W-1:0]  word_rd;
   logic [DATA_W-1:0]  word_sh;
   logic [DATA_W-1:0]  load_ext;
   logic               sign_bit;
   logic [7:0]         fill;
   logic [NB-1:0]      wr_lanes;
   logic [DATA_W-1:0]  wdata_sh;

   // ---------------------------------------------------------------------
   // Access decode and fault detection
   // ---------------------------------------------------------------------
   assign rd_any   = |MemRead_EXE;
   assign wr_any   = |MemWrite_EXE;
   assign acc_mask = rd_any ? MemRead_EXE : MemWrite_EXE;
   assign off      = ALU_Result_EXE_MEM[OB-1:0];
   assign idx      = ALU_Result_EXE_MEM[OB+IW-1:OB];

   // A legal mask is one of 1, 3, 15, ... (2^j low ones). off_mask becomes
   // k-1, so any offset bit under it means the access is not size-aligned.
   always_comb begin
      size_ok  = 1'b0;
      off_mask = '0;
      for (int j = 0; j <= OB; j++) begin
         if (acc_mask == (ONES >> (NB - (1 << j)))) begin
            size_ok  = 1'b1;
            off_mask = OB'((1 << j) - 1);
         end
      end
   end

   assign misalign = |(off & off_mask);
   assign fault    = valid_EXE_MEM &
                     ((rd_any & wr_any) |
                      ((rd_any | wr_any) & (~size_ok | misalign)));
   assign memop    = valid_EXE_MEM & (rd_any | wr_any) & ~fault;

   assign stall_int = memop & (cnt_q != LAT);
   assign complete  = memop & (cnt_q == LAT);
   assign stall_MEM = stall_int;

   // ---------------------------------------------------------------------
   // Latency FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Dropping out of WAIT whenever no memop is presented keeps the counter
   // from getting stuck if upstream ever withdraws a pending access.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (stall_int) begin
         cnt_d   = cnt_q + 3'd1;
         state_d = S_WAIT;
      end else begin
         cnt_d   = '0;
         state_d = S_IDLE;
      end
   end

   // ---------------------------------------------------------------------
   // Data memory: no reset, lane-masked write on the completing edge
   // ---------------------------------------------------------------------
   assign wr_lanes = MemWrite_EXE << off;
   assign wdata_sh = write_data_EXE_MEM << {off, 3'b000};

   always_ff @(posedge clk) begin
      if (complete && wr_any) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_lanes[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   // Load path: right-align the addressed bytes, then replace every byte
   // above the access size with the fill byte. The sign comes from the top
   // byte inside the mask (last match in the ascending loop).
   assign word_rd = mem[idx];
   assign word_sh = word_rd >> {off, 3'b000};

   always_comb begin
      sign_bit = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (MemRead_EXE[b]) sign_bit = word_sh[8*b+7];
      end
      fill = (LoadSigned_EXE && sign_bit) ? 8'hFF : 8'h00;
      load_ext = '0;
      for (int b = 0; b < NB; b++) begin
         load_ext[8*b +: 8] = MemRead_EXE[b] ? word_sh[8*b +: 8] : fill;
      end
   end

   // ---------------------------------------------------------------------
   // MEM/WB register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_data_MEM_WB  <= '0;
         ALU_Result_MEM_WB <= '0;
         MemtoReg_MEM_WB   <= '0;
         RegWrite_MEM_WB   <= 1'b0;
         write_reg_MEM_WB  <= '0;
         pc_MEM_WB         <= '0;
         valid_MEM_WB      <= 1'b0;
         fault_MEM_WB      <= 1'b0;
      end else if (!valid_EXE_MEM || stall_int) begin
         read_data_MEM_WB  <= '0;
         ALU_Result_MEM_WB <= '0;
         MemtoReg_MEM_WB   <= '0;
         RegWrite_MEM_WB   <= 1'b0;
         write_reg_MEM_WB  <= '0;
         pc_MEM_WB         <= '0;
         valid_MEM_WB      <= 1'b0;
         fault_MEM_WB      <= 1'b0;
      end else begin
         read_data_MEM_WB  <= (rd_any && !fault) ? load_ext : '0;
         ALU_Result_MEM_WB <= ALU_Result_EXE_MEM;
         MemtoReg_MEM_WB   <= MemtoReg_EXE_MEM;
         RegWrite_MEM_WB   <= RegWrite_EXE_MEM & ~fault;
         write_reg_MEM_WB  <= rd_EXE_MEM;
         pc_MEM_WB         <= DATA_W'(pc_EXE_MEM);
         valid_MEM_WB      <= 1'b1;
         fault_MEM_WB      <= fault;
      end
   end

endmodule

// File: doc/mem_stage_param.md
# mem_stage_param

Parametrised successor to the MEM pipeline stage. It sits between the EXE/MEM and MEM/WB pipeline registers and owns the word-organised data memory. Loads and stores use byte-lane masks with address-offset lane steering and sign or zero extension on loads. It detects misaligned and illegal accesses, and models a configurable memory latency by stalling upstream with a counter-driven handshake.

## Interface
- DATA_W, 32, data and address width in bits; must be 8·2^n.
- DEPTH, 1024, memory depth in DATA_W words; must be a power of two.
- PC_W, 15, width of the incoming PC.
- REG_W, 5, register index width.
- MEM_LAT, 1, wait cycles per memory access (0–7).
- NB is derived as DATA_W/8, the number of byte lanes. OB is derived as log2(NB).

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_EXE_MEM  in  1  the instruction in EXE/MEM is valid.
- MemRead_EXE  in  NB  load size mask: low-contiguous ones, count ∈ {1,2,4..NB}.
- MemWrite_EXE  in  NB  store size mask, same encoding.
- LoadSigned_EXE  in  1  1 selects sign-extension on load, 0 selects zero-extension.
- ALU_Result_EXE_MEM  in  DATA_W  byte address, or ALU result for non-memory ops.
- write_data_EXE_MEM  in  DATA_W  store data, LSB-aligned.
- MemtoReg_EXE_MEM  in  2  writeback select; passed through.
- RegWrite_EXE_MEM  in  1  register write enable.
- rd_EXE_MEM  in  REG_W  destination register.
- pc_EXE_MEM  in  PC_W  instruction PC.
- stall_MEM  out  1  stage busy; upstream must hold all inputs stable.
- read_data_MEM_WB  out  DATA_W  extended load data.
- ALU_Result_MEM_WB  out  DATA_W  registered ALU_Result_EXE_MEM.
- MemtoReg_MEM_WB  out  2  registered MemtoReg.
- RegWrite_MEM_WB  out  1  registered RegWrite, gated by valid and fault.
- write_reg_MEM_WB  out  REG_W  registered rd.
- pc_MEM_WB  out  DATA_W  registered PC, zero-extended.
- valid_MEM_WB  out  1  the MEM/WB contents are a real instruction.
- fault_MEM_WB  out  1  the access was misaligned or illegal; no effect on memory.

## Operation
- **Access size.** k is the number of ones in the nonzero mask. The byte offset off is addr[OB-1:0]. The word index is addr[OB+log2(DEPTH)-1:OB]; higher address bits are ignored, so the index wraps modulo DEPTH.
- **Fault conditions.** A fault occurs when valid=1 and any of the following holds:
  - both masks are nonzero;
  - a mask is nonzero and not low-contiguous with a power-of-two count;
  - off mod k ≠ 0.
- **Effect of a fault.** No memory access and no stall. The instruction completes in 1 cycle with fault_MEM_WB=1, RegWrite_MEM_WB=0 and read_data_MEM_WB=0.
- **Store.** Lanes are MemWrite_EXE << off. Data is write_data_EXE_MEM << 8·off. Only the enabled lanes of mem[index] are written, at the completing edge.
- **Load.** The bytes [off .. off+k-1] of mem[index] are right-aligned, then sign-extended from bit 8k-1 when LoadSigned_EXE=1, otherwise zero-extended.
- **Non-memory op** (both masks 0): passes through in 1 cycle, no stall, read_data_MEM_WB=0.
- **Bubble input** (valid_EXE_MEM=0): all MEM/WB outputs load 0 and valid_MEM_WB=0.
- **Latency counter.** cnt is 3 bits; its reset value is 0. Define memop = valid & (read|write mask nonzero) & !fault.
  - stall_MEM is combinational: memop & (cnt != MEM_LAT).
  - Each edge with stall_MEM=1: cnt increments, and MEM/WB loads a bubble (all outputs 0, valid 0).
  - Completing edge (memop with cnt == MEM_LAT): the access is performed, MEM/WB loads the instruction with valid=1, and cnt returns to 0.
  - States: IDLE (cnt=0) and WAIT (cnt>0). IDLE→WAIT on memop when MEM_LAT>0. WAIT→IDLE on the completing edge.
- **Memory contents.** Not cleared by reset. Contents are undefined at power-up.

## Timing
- **Reset values.** All outputs 0, including stall_MEM, valid_MEM_WB and fault_MEM_WB. cnt resets to 0 asynchronously.
- **Latency.** A memory op completes MEM_LAT+1 edges after it is presented. A non-memory or fault op completes in 1 edge.
- **Throughput.** Back-to-back non-memory ops have no gaps. A memory op occupies MEM_LAT+1 cycles.
- **Reset during WAIT.** The pending store is not committed, cnt returns to 0 and outputs return to 0.
- **MEM_LAT=0.** stall_MEM is never asserted.
- **Load after store.** A load following a store to the same word sees the stored data, because the write commits before the load completes.

## Test plan
Bench configuration for all scenarios: DATA_W=32, DEPTH=1024, MEM_LAT=2.
- **Reset.** Hold reset_n=0 → every output is 0 and stall_MEM=0. Release reset → with a non-memory op (rd=5, pc=0x0E, ALU=0x7), the next edge gives write_reg=5, pc_MEM_WB=0x0000000E, valid=1, no stall.
- **Word store/load.** Store 0x000ABCDE at addr 16, mask 1111 → stall_MEM high for 2 cycles, MEM/WB holds bubbles, valid=1 on the 3rd edge. Then word load at addr 16 → read_data=0x000ABCDE.
- **Byte lanes and extension.** Byte store 0xAB at addr 0x13 (mask 0001) → word load at 0x10 returns 0xAB0ABCDE. Signed byte load at 0x13 → 0xFFFFFFAB; unsigned → 0x000000AB. Signed halfword load at 0x12 → 0xFFFFAB0A.
- **Faults.** Halfword load at 0x11 → fault=1, RegWrite=0, read_data=0, no stall. Word store at 0x12 → fault=1 and memory unchanged. Read and write masks both 1111 → fault=1.
- **Wrap-around.** Word store 0x12345678 at addr 4096 → word load at addr 0 returns 0x12345678.
- **Reset mid-operation.** Start a word store of 0xDEADBEEF to addr 0x20. Pulse reset_n low during the 1st stall cycle → outputs go to 0 immediately. A subsequent load at 0x20 returns the prior contents, not 0xDEADBEEF.
